// File: rtl/convolution_controller.sv
// convolution_controller: collects 3x3 pixel windows, feeds an external 3-lane multiply-accumulate
// array in three rounds and streams out window sums. Define CONV_READBACK_EN for register readback.
module convolution_controller #(
  parameter int unsigned BIT_LENGTH       = 16,
  parameter int unsigned INPUT_PORT_COUNT = 3,
  parameter int unsigned MULT_LATENCY     = 4
) (
  input  logic                                   axi_clk,
  input  logic                                   axi_reset,
  output logic                                   ip_reset_out,
  input  logic [31:0]                            cSum,
  input  logic                                   cReady,
  output logic [INPUT_PORT_COUNT*BIT_LENGTH-1:0] MULTIPLIER_INPUT,
  output logic [INPUT_PORT_COUNT*BIT_LENGTH-1:0] MULTIPLICAND_INPUT,
  output logic [INPUT_PORT_COUNT-1:0]            MULTIPLY_START,
  output logic                                   FINALADDOUT,
  input  logic                                   s_axis_valid,
  input  logic [31:0]                            s_axis_data,
  input  logic                                   s_axis_last,
  input  logic [3:0]                             s_axis_keep,
  output logic                                   s_axis_ready,
  output logic                                   m_axis_valid,
  output logic [31:0]                            m_axis_data,
  output logic                                   m_axis_last,
  output logic [3:0]                             m_axis_keep,
  input  logic                                   m_axis_ready,
  input  logic [9:0]                             s_axi_awaddr,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [31:0]                            s_axi_wdata,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [9:0]                             s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [31:0]                            s_axi_rdata,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StMult   = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StFinal  = 3'd4;
  localparam logic [2:0] StResult = 3'd5;
  localparam logic [2:0] StOut    = 3'd6;
  localparam logic [2:0] StClear  = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [31:0]           width_q, height_q;
  logic                  enable_q, enable_prev_q;
  logic [BIT_LENGTH-1:0] coef_q [9];
  logic [BIT_LENGTH-1:0] pix_q  [9];
  logic [3:0]            pix_cnt_q;
  logic                  drop_q;
  logic [1:0]            round_q;
  logic [15:0]           wait_cnt_q;
  logic [31:0]           win_cnt_q;
  logic [31:0]           sum_q;
  logic                  last_win_q;
  logic                  bvalid_q, rvalid_q;

  logic        wr_en, rd_en, beat, load_beat, load_done, en_rise, pix_clear;
  logic        is_last_win, operands_valid;
  logic [31:0] n_windows;
  logic [3:0]  lane_idx;

  assign wr_en     = s_axi_awvalid && s_axi_wvalid;
  assign rd_en     = s_axi_arvalid && !rvalid_q;
  assign en_rise   = enable_q && !enable_prev_q;
  assign beat      = s_axis_valid && s_axis_ready;
  assign load_beat = beat && !drop_q && (state_q == StLoad);
  assign load_done = load_beat && ((pix_cnt_q == 4'd8) || s_axis_last);
  assign pix_clear = ((state_q == StIdle) && en_rise) || (state_q == StClear);

  // Degenerate geometry still yields one window so a frame always terminates.
  always_comb begin
    n_windows = 32'd1;
    if ((width_q >= 32'd3) && (height_q >= 32'd3)) begin
      n_windows = (width_q - 32'd2) * (height_q - 32'd2);
    end
  end

  assign is_last_win = (win_cnt_q + 32'd1) == n_windows;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (en_rise) state_d = StLoad;
      StLoad:   if (load_done) state_d = StMult;
      StMult:   state_d = (round_q == 2'd2) ? StFinal : StWait;
      StWait:   if ((32'(wait_cnt_q) + 32'd1) >= MULT_LATENCY) state_d = StMult;
      StFinal:  state_d = StResult;
      StResult: if (cReady) state_d = StOut;
      StOut:    if (m_axis_ready) state_d = StClear;
      StClear:  state_d = (last_win_q || !enable_q) ? StIdle : StLoad;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q       <= StIdle;
      width_q       <= '0;
      height_q      <= '0;
      enable_q      <= 1'b0;
      enable_prev_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= '0;
        pix_q[i]  <= '0;
      end
      pix_cnt_q  <= '0;
      drop_q     <= 1'b0;
      round_q    <= '0;
      wait_cnt_q <= '0;
      win_cnt_q  <= '0;
      sum_q      <= '0;
      last_win_q <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_prev_q <= enable_q;

      if (wr_en) begin
        case (s_axi_awaddr)
          10'h000: width_q  <= s_axi_wdata;
          10'h004: height_q <= s_axi_wdata;
          10'h008: enable_q <= s_axi_wdata[0];
          default: ;
        endcase
        for (int i = 0; i < 9; i++) begin
          if (s_axi_awaddr == 10'(16 + 4 * i)) coef_q[i] <= s_axi_wdata[BIT_LENGTH-1:0];
        end
      end
      bvalid_q <= wr_en || (bvalid_q && !s_axi_bready);

      if (rd_en) begin
        rvalid_q <= 1'b1;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (pix_clear) begin
        for (int i = 0; i < 9; i++) pix_q[i] <= '0;
        pix_cnt_q <= '0;
      end else if (load_beat) begin
        pix_q[pix_cnt_q] <= s_axis_data[BIT_LENGTH-1:0];
        pix_cnt_q        <= pix_cnt_q + 4'd1;
      end

      // A full window without last leaves the rest of the packet to be swallowed.
      if (load_beat && (pix_cnt_q == 4'd8) && !s_axis_last) begin
        drop_q <= 1'b1;
      end else if (beat && drop_q && s_axis_last) begin
        drop_q <= 1'b0;
      end

      if (load_done) begin
        round_q <= '0;
      end else if (state_q == StMult) begin
        round_q <= round_q + 2'd1;
      end

      if (state_q == StMult) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      if ((state_q == StResult) && cReady) begin
        sum_q      <= cSum;
        last_win_q <= is_last_win;
      end

      if ((state_q == StIdle) && en_rise) begin
        win_cnt_q <= '0;
      end else if (state_q == StClear) begin
        win_cnt_q <= win_cnt_q + 32'd1;
      end
    end
  end

  assign operands_valid = (state_q == StMult) || (state_q == StWait);

  always_comb begin
    MULTIPLIER_INPUT   = '0;
    MULTIPLICAND_INPUT = '0;
    lane_idx           = '0;
    for (int k = 0; k < int'(INPUT_PORT_COUNT); k++) begin
      lane_idx = 4'(round_q) * 4'd3 + 4'(k);
      if (operands_valid && (lane_idx < 4'd9)) begin
        MULTIPLIER_INPUT[k*BIT_LENGTH +: BIT_LENGTH]   = pix_q[lane_idx];
        MULTIPLICAND_INPUT[k*BIT_LENGTH +: BIT_LENGTH] = coef_q[lane_idx];
      end
    end
  end

  assign MULTIPLY_START = (state_q == StMult) ? '1 : '0;
  assign FINALADDOUT    = (state_q == StFinal);
  assign ip_reset_out   = pix_clear;

  assign s_axis_ready = (state_q == StLoad) || drop_q;
  assign m_axis_valid = (state_q == StOut);
  assign m_axis_data  = m_axis_valid ? sum_q : '0;
  assign m_axis_last  = m_axis_valid && last_win_q;
  assign m_axis_keep  = m_axis_valid ? 4'hF : 4'h0;

  assign s_axi_awready = 1'b1;
  assign s_axi_wready  = 1'b1;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;

`ifdef CONV_READBACK_EN
  logic        frame_done_q;
  logic [31:0] rdata_q, rd_mux;
  logic        busy;

  assign busy = (state_q != StIdle);

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr)
      10'h000: rd_mux = width_q;
      10'h004: rd_mux = height_q;
      10'h008: rd_mux = {31'b0, enable_q};
      10'h00C: rd_mux = {30'b0, frame_done_q, busy};
      default: ;
    endcase
    for (int i = 0; i < 9; i++) begin
      if (s_axi_araddr == 10'(16 + 4 * i)) rd_mux = 32'(coef_q[i]);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      frame_done_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (rd_en) rdata_q <= rd_mux;
      if ((state_q == StIdle) && en_rise) begin
        frame_done_q <= 1'b0;
      end else if ((state_q == StClear) && last_win_q) begin
        frame_done_q <= 1'b1;
      end
    end
  end

  assign s_axi_rdata = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{s_axis_keep, s_axis_data};
`else
  assign s_axi_rdata = '0;

  logic unused_ok;
  assign unused_ok = ^{s_axis_keep, s_axis_data, s_axi_araddr};
`endif

endmodule

// File: tb/tb_convolution_controller.sv
// Scoreboard bench for convolution_controller: random packets, a behavioural accelerator model,
// and a reference window-sum model feeding an expected-result queue.
module tb_convolution_controller;
  localparam int BL  = 16;
  localparam int IPC = 3;
  localparam int ML  = 4;

  logic              axi_clk = 1'b0;
  logic              axi_reset;
  logic              ip_reset_out;
  logic [31:0]       cSum;
  logic              cReady;
  logic [IPC*BL-1:0] MULTIPLIER_INPUT, MULTIPLICAND_INPUT;
  logic [IPC-1:0]    MULTIPLY_START;
  logic              FINALADDOUT;
  logic              s_axis_valid, s_axis_last, s_axis_ready;
  logic [31:0]       s_axis_data;
  logic [3:0]        s_axis_keep;
  logic              m_axis_valid, m_axis_last, m_axis_ready;
  logic [31:0]       m_axis_data;
  logic [3:0]        m_axis_keep;
  logic [9:0]        s_axi_awaddr, s_axi_araddr;
  logic              s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]       s_axi_wdata, s_axi_rdata;
  logic              s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic              s_axi_rvalid, s_axi_rready;

  always #5 axi_clk = ~axi_clk;

  convolution_controller #(.BIT_LENGTH(BL), .INPUT_PORT_COUNT(IPC), .MULT_LATENCY(ML)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .ip_reset_out(ip_reset_out),
    .cSum(cSum), .cReady(cReady),
    .MULTIPLIER_INPUT(MULTIPLIER_INPUT), .MULTIPLICAND_INPUT(MULTIPLICAND_INPUT),
    .MULTIPLY_START(MULTIPLY_START), .FINALADDOUT(FINALADDOUT),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_keep(s_axis_keep), .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_keep(m_axis_keep), .m_axis_ready(m_axis_ready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_coef[9];
  int unsigned m_w = 0, m_h = 0, m_win = 0;
  logic        m_en = 1'b0;
  logic [15:0] pkt[16];
  int          pkt_len;
  int          stall_len = -1;
  logic        strict = 1'b0;
  logic        mon_en = 1'b1;
  logic        ip_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  function automatic int unsigned n_win();
    if (m_w < 3 || m_h < 3) return 1;
    return (m_w - 2) * (m_h - 2);
  endfunction

  // Window sum straight from the definition: first nine beats, zero beyond the packet.
  function automatic logic [31:0] ref_sum();
    longint unsigned s = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < pkt_len) s += longint'(pkt[i]) * longint'(m_coef[i]);
    end
    return s[31:0];
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] v);
`ifdef CONV_READBACK_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data);
    s_axi_awaddr = addr; s_axi_wdata = data;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(posedge axi_clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    ip_seen = ip_reset_out;
    check("bvalid_rise", 32'(s_axi_bvalid), 1);
    s_axi_bready = 1'b1;
    @(posedge axi_clk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_clear", 32'(s_axi_bvalid), 0);
    if (addr == 10'h000) m_w = data;
    if (addr == 10'h004) m_h = data;
    if (addr == 10'h008) begin
      if (data[0] && !m_en) m_win = 0;
      m_en = data[0];
    end
    if (addr >= 10'h010 && addr <= 10'h030 && addr[1:0] == 2'b00) m_coef[(addr - 16) / 4] = data[15:0];
  endtask

  task automatic axi_read(input logic [9:0] addr, input logic [31:0] v, input string name);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    @(posedge axi_clk); #1;
    s_axi_arvalid = 1'b0;
    check({name, "_rvalid"}, 32'(s_axi_rvalid), 1);
    check({name, "_arready_low"}, 32'(s_axi_arready), 0);
    check(name, s_axi_rdata, rd_exp(v));
    s_axi_rready = 1'b1;
    @(posedge axi_clk); #1;
    s_axi_rready = 1'b0;
    check({name, "_rvalid_clear"}, 32'(s_axi_rvalid), 0);
  endtask

  task automatic send_packet();
    exp_t e;
    int   n;
    e.data = ref_sum();
    e.last = (m_win == n_win() - 1);
    exp_q.push_back(e);
    m_win++;
    for (int i = 0; i < pkt_len; i++) begin
      if ($urandom_range(3) == 0) repeat ($urandom_range(2) + 1) begin @(posedge axi_clk); #1; end
      s_axis_valid = 1'b1;
      s_axis_data  = {16'($urandom), pkt[i]};
      s_axis_last  = (i == pkt_len - 1);
      n = 0;
      do begin @(negedge axi_clk); n++; end while (!s_axis_ready && n < 1000);
      if (!s_axis_ready) begin
        check("beat_accept_timeout", 32'(s_axis_ready), 1);
        s_axis_valid = 1'b0;
        return;
      end
      @(posedge axi_clk); #1;
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
    end
  endtask

  task automatic rand_packet(input int len);
    pkt_len = len;
    for (int i = 0; i < 16; i++) pkt[i] = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(posedge axi_clk); n++; end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
    repeat (3) @(posedge axi_clk);
    #1;
  endtask

  // Accelerator model: accumulate lane products per start, answer FINALADDOUT after a short delay.
  initial begin
    int          since, starts, cd;
    logic [31:0] acc;
    cReady = 1'b0; cSum = '0; since = 0; starts = 0; cd = -1; acc = '0;
    forever begin
      @(negedge axi_clk);
      since++;
      cReady = 1'b0;
      if (axi_reset) begin
        acc = '0; cd = -1; starts = 0;
      end else begin
        if (ip_reset_out) begin acc = '0; starts = 0; end
        if (MULTIPLY_START == '1) begin
          for (int k = 0; k < IPC; k++)
            acc += 32'(MULTIPLIER_INPUT[k*BL +: BL]) * 32'(MULTIPLICAND_INPUT[k*BL +: BL]);
          if (starts > 0) check("start_spacing", 32'(since), ML + 1);
          starts++;
          since = 0;
        end
        if (FINALADDOUT) begin
          check("rounds_before_final", 32'(starts), 3);
          starts = 0;
          cd = $urandom_range(2);
        end else if (cd == 0) begin
          cReady = 1'b1; cSum = acc; cd = -1;
        end else if (cd > 0) begin
          cd--;
        end
      end
    end
  end

  // Output monitor: stalls, checks hold stability, then pops the scoreboard.
  initial begin
    exp_t        e;
    logic [31:0] d0;
    logic        l0;
    int          hold;
    m_axis_ready = 1'b0;
    forever begin
      @(negedge axi_clk);
      if (mon_en && m_axis_valid) begin
        hold = (stall_len >= 0) ? stall_len : int'($urandom_range(3));
        d0 = m_axis_data; l0 = m_axis_last;
        check("m_keep", 32'(m_axis_keep), 32'hF);
        for (int j = 0; j < hold; j++) begin
          @(negedge axi_clk);
          check("hold_valid", 32'(m_axis_valid), 1);
          check("hold_data", m_axis_data, d0);
          check("hold_last", 32'(m_axis_last), 32'(l0));
          if (strict) check("s_ready_during_out", 32'(s_axis_ready), 0);
        end
        m_axis_ready = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(m_axis_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("window_sum", m_axis_data, e.data);
          check("window_last", 32'(m_axis_last), 32'(e.last));
        end
        @(negedge axi_clk);
        m_axis_ready = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    axi_reset = 1'b1;
    s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0; s_axis_keep = 4'hF;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < 9; i++) m_coef[i] = '0;
    repeat (3) @(posedge axi_clk);
    #1;
    check("rst_s_ready", 32'(s_axis_ready), 0);
    check("rst_m_valid", 32'(m_axis_valid), 0);
    check("rst_m_data", m_axis_data, 0);
    check("rst_start", 32'(MULTIPLY_START), 0);
    check("rst_final", 32'(FINALADDOUT), 0);
    check("rst_ip_reset", 32'(ip_reset_out), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_rvalid", 32'(s_axi_rvalid), 0);
    check("rst_awready", 32'(s_axi_awready), 1);
    check("rst_wready", 32'(s_axi_wready), 1);
    check("rst_arready", 32'(s_axi_arready), 1);
    check("rst_mult_in", 32'(MULTIPLIER_INPUT), 0);
    axi_reset = 1'b0;
    @(posedge axi_clk); #1;

    // Frame 1: 4x3 geometry, COEF[i]=i, two windows.
    axi_write(10'h000, 4);
    axi_write(10'h004, 3);
    for (int i = 0; i < 9; i++) axi_write(10'(16 + 4 * i), i);
    axi_read(10'h000, 4, "rd_width");
    axi_read(10'h004, 3, "rd_height");
    axi_read(10'h024, 5, "rd_coef5");
    axi_read(10'h040, 0, "rd_unmapped");
    axi_write(10'h008, 1);
    check("ip_reset_on_enable", 32'(ip_seen), 1);
    pkt_len = 9;
    for (int i = 0; i < 9; i++) pkt[i] = 16'(9 + i);
    send_packet();
    stall_len = 10; strict = 1'b1;
    pkt_len = 3;
    for (int i = 0; i < 3; i++) pkt[i] = 16'(i);
    send_packet();
    drain();
    stall_len = -1; strict = 1'b0;
    check("idle_s_ready_after_frame", 32'(s_axis_ready), 0);
    axi_read(10'h00C, 2, "rd_status_done");

    // Frame 2: 4x4, leading 12-beat packet then random lengths.
    axi_write(10'h008, 0);
    axi_write(10'h000, 4);
    axi_write(10'h004, 4);
    axi_write(10'h008, 1);
    rand_packet(12);
    send_packet();
    for (int w = 1; w < 4; w++) begin rand_packet($urandom_range(1, 12)); send_packet(); end
    drain();

    // Frame 3: enable dropped during the first window; only that window completes.
    axi_write(10'h008, 0);
    axi_write(10'h000, 5);
    axi_write(10'h004, 5);
    axi_write(10'h008, 1);
    rand_packet(9);
    send_packet();
    axi_write(10'h008, 0);
    drain();
    check("idle_after_disable", 32'(s_axis_ready), 0);
    axi_read(10'h00C, 0, "rd_status_abort");

    // Random frames with random geometry and coefficients.
    for (int f = 0; f < 3; f++) begin
      axi_write(10'h000, $urandom_range(2, 6));
      axi_write(10'h004, $urandom_range(2, 5));
      for (int i = 0; i < 9; i++) axi_write(10'(16 + 4 * i), 32'($urandom));
      axi_write(10'h008, 1);
      for (int unsigned w = 0; w < n_win(); w++) begin
        rand_packet($urandom_range(1, 12));
        send_packet();
      end
      drain();
      axi_write(10'h008, 0);
    end

    // Reset in the middle of the multiply rounds.
    mon_en = 1'b0;
    axi_write(10'h008, 1);
    rand_packet(9);
    send_packet();
    n = 0;
    while (MULTIPLY_START != '1 && n < 200) begin @(negedge axi_clk); n++; end
    check("saw_mult_before_reset", 32'(MULTIPLY_START), 32'((1 << IPC) - 1));
    axi_reset = 1'b1;
    @(posedge axi_clk); #1;
    check("mrst_start", 32'(MULTIPLY_START), 0);
    check("mrst_final", 32'(FINALADDOUT), 0);
    check("mrst_s_ready", 32'(s_axis_ready), 0);
    check("mrst_m_valid", 32'(m_axis_valid), 0);
    check("mrst_ip_reset", 32'(ip_reset_out), 0);
    check("mrst_mult_in", 32'(MULTIPLIER_INPUT), 0);
    check("mrst_arready", 32'(s_axi_arready), 1);
    axi_reset = 1'b0;
    exp_q.delete();
    m_w = 0; m_h = 0; m_en = 1'b0;
    @(posedge axi_clk); #1;
    axi_read(10'h00C, 0, "rd_status_after_reset");
    axi_read(10'h000, 0, "rd_width_after_reset");
    repeat (5) @(posedge axi_clk);
    check("no_output_after_reset", 32'(m_axis_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/convolution_controller.md
# convolution_controller

Control and data-marshalling block for the 3x3 convolution accelerator. It takes frame geometry and nine filter coefficients over an AXI4-Lite-style register port, collects 3x3 pixel windows from an AXI4-Stream slave, and feeds the external `matrixAccelerator` in three multiply rounds of three products each. It returns each accumulated window sum (`cSum`) on an AXI4-Stream master.

## Interface
- `BIT_LENGTH`, default 16: width of each multiplier operand; taken from `data[BIT_LENGTH-1:0]`.
- `INPUT_PORT_COUNT`, default 3: number of parallel multipliers.
- `MULT_LATENCY`, default 4: cycles between consecutive `MULTIPLY_START` pulses; ≥ multiplier latency.
- `axi_clk` in 1: single clock; everything samples on the rising edge.
- `axi_reset` in 1: synchronous, active-high reset.
- `ip_reset_out` out 1: one-cycle accelerator clear.
- `cSum` in 32: accelerator final accumulate.
- `cReady` in 1: `cSum` valid.
- `MULTIPLIER_INPUT` out `INPUT_PORT_COUNT*BIT_LENGTH`: flat pixel operands; lane k is bits `[k*BIT_LENGTH +: BIT_LENGTH]`.
- `MULTIPLICAND_INPUT` out `INPUT_PORT_COUNT*BIT_LENGTH`: flat coefficient operands, same lane layout.
- `MULTIPLY_START` out `INPUT_PORT_COUNT`: per-lane multiply start.
- `FINALADDOUT` out 1: final-add strobe.
- `s_axis_valid`, `s_axis_data[31:0]`, `s_axis_last`, `s_axis_keep[3:0]` in; `s_axis_ready` out: pixel stream. `keep` is ignored.
- `m_axis_valid`, `m_axis_data[31:0]`, `m_axis_last`, `m_axis_keep[3:0]` out; `m_axis_ready` in: result stream.
- `s_axi_awaddr[9:0]`, `s_axi_awvalid`, `s_axi_wdata[31:0]`, `s_axi_wvalid`, `s_axi_bready`, `s_axi_araddr[9:0]`, `s_axi_arvalid`, `s_axi_rready` in.
- `s_axi_awready`, `s_axi_wready`, `s_axi_bvalid`, `s_axi_arready`, `s_axi_rdata[31:0]`, `s_axi_rvalid` out.

## Operation
- Register map (byte addresses):
  - 0x00 WIDTH.
  - 0x04 HEIGHT.
  - 0x08 CTRL (bit0 enable).
  - 0x0C STATUS (read-only; bit0 busy, bit1 frame_done).
  - 0x10–0x30 COEF[0..8], at address 0x10+4i.
  - Writes to other addresses are ignored; reads of other addresses return 0.
- Write acceptance:
  - A write is accepted in any cycle with `awvalid && wvalid`. `awready` and `wready` are held at 1.
  - `bvalid` rises the next cycle and holds until `bready`.
- Windows per frame: N = (WIDTH−2)*(HEIGHT−2). If WIDTH<3 or HEIGHT<3, N = 1.
- FSM states: IDLE, LOAD, MULT, WAIT, FINAL, RESULT, OUT, CLEAR.
- IDLE: when enable rises 0→1, pulse `ip_reset_out`, clear the window counter and frame_done, then go to LOAD.
- LOAD:
  - `s_axis_ready`=1. Each beat stores `data[BIT_LENGTH-1:0]` into pixel slot p = 0..8, row-major.
  - The state ends after the 9th beat, or on a beat with `s_axis_last`. Unfilled slots are zero.
  - Beats beyond 9 in a packet are accepted and discarded until `last`; the next window starts on the following packet.
- MULT round r = 0..2:
  - Lane k carries pixel[3r+k] and COEF[3r+k].
  - `MULTIPLY_START`=all-ones for exactly one cycle.
  - Go to WAIT for `MULT_LATENCY` cycles, then the next round. After round 2, go to FINAL.
- FINAL: `FINALADDOUT`=1 for one cycle, then go to RESULT.
- RESULT: wait for `cReady`, latch `cSum`, go to OUT.
- OUT:
  - `m_axis_valid`=1, `m_axis_data`=latched sum, `m_axis_keep`=4'hF.
  - `m_axis_last`=1 when this is window N of the frame.
  - Hold until `m_axis_ready`, then go to CLEAR.
- CLEAR:
  - Pulse `ip_reset_out` for one cycle.
  - If this was window N, set frame_done and go to IDLE; otherwise go to LOAD.
  - Re-arming requires writing enable 0 then 1.
- Enable cleared mid-operation: finish the current window through CLEAR, then go to IDLE.
- COEF, WIDTH and HEIGHT writes during a window take effect at the next MULT round; software writes them only while idle.
- Operands are unsigned. The 32-bit result is passed through unmodified.

## Timing
- Reset values: all outputs 0 except `s_axi_awready`, `s_axi_wready` and `s_axi_arready`, which are 1. Registers reset to 0.
- `ip_reset_out` is driven the cycle after the enable write is accepted.
- Minimum latency from the last LOAD beat to `m_axis_valid`: 3 MULT cycles + 2·`MULT_LATENCY` + FINAL + RESULT + `cReady` latency.
- Read: `arvalid` is sampled with `arready`=1. `rvalid`/`rdata` appear the next cycle and hold until `rready`. `arready`=0 while `rvalid` is pending.
- Simultaneous write and read are both served. A read of a register written in the same cycle returns the old value.

## Configuration
- `CONV_READBACK_EN`:
  - Defined: register read path as above.
  - Undefined: `rdata` is constant 0, `rvalid` still handshakes normally, and the STATUS logic is removed.

## Test plan
- Reset, then write WIDTH=4, HEIGHT=3 -> each write gets `bvalid` the next cycle; with readback, reading 0x00/0x04 returns 4/3.
- COEF[i]=i, enable, stream 9..17 with `last` on 17 -> lanes (9,0),(10,1),(11,2), then (12,3)…, three START pulses `MULTIPLY_START_spacing`=`MULT_LATENCY`+1 cycles apart, then FINALADDOUT; with a model accelerator, `m_axis_data`=528 and `m_axis_last`=0.
- Then stream 0,1,2 with `last` on 2 -> zero-padded window; `m_axis_data`=5, `m_axis_last`=1; STATUS=0b10.
- Hold `m_axis_ready`=0 for 10 cycles -> `m_axis_valid`/data stable and `s_axis_ready`=0 until the handshake.
- Packet of 12 beats -> first 9 used, 3 discarded, result as for the first 9.
- Assert `axi_reset` during MULT -> all outputs return to reset values on the next edge, and state is IDLE.
